// File: rtl/biu_mem_arb_pkg.sv
// biu_mem_arb_pkg: shared constants and types for the BIU memory arbiter.
//   PC_SIZE / XLEN : default address and data widths
//   arb_state_e    : arbiter FSM encoding (IDLE / HOLD / RSP)
//   ARB_OWN_*      : owner encoding used by the owner and round-robin registers
package biu_mem_arb_pkg;

    localparam int PC_SIZE = 32;
    localparam int XLEN    = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_e;

    localparam logic ARB_OWN_IFU = 1'b0;
    localparam logic ARB_OWN_LSU = 1'b1;

endpackage

// File: rtl/biu_mem_arb_if.sv
// biu_mem_arb_if: bundles the IFU, LSU and memory request/response channels.
//   master modport : the arbiter's view (drives mem_req_*, requester ready and
//                    requester response channels)
//   slave modport  : the environment's view (requesters and memory model)
// Handshake rule for every channel: a transfer happens in a cycle where both
// valid and ready are high at the rising clock edge; a source holds its payload
// stable while valid is high and ready is low.
interface biu_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_req_pc;
    logic          ifu_rsp_valid;
    logic          ifu_rsp_ready;
    logic [DW-1:0] ifu_rsp_instr;
    logic          ifu_rsp_err;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [AW-1:0]   lsu_req_addr;
    logic            lsu_req_write;
    logic [DW-1:0]   lsu_req_wdata;
    logic [DW/8-1:0] lsu_req_wstrb;
    logic            lsu_rsp_valid;
    logic            lsu_rsp_ready;
    logic [DW-1:0]   lsu_rsp_rdata;
    logic            lsu_rsp_err;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_write;
    logic [DW-1:0]   mem_req_wdata;
    logic [DW/8-1:0] mem_req_wstrb;
    logic            mem_rsp_valid;
    logic            mem_rsp_ready;
    logic [DW-1:0]   mem_rsp_rdata;
    logic            mem_rsp_err;

    modport master (
        input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata, lsu_req_wstrb, lsu_rsp_ready,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

    modport slave (
        output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata, lsu_req_wstrb, lsu_rsp_ready,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/biu_mem_arb_rr.sv
// biu_rr_arb2: combinational two-way round-robin grant.
//   last_i      : 1 when the LSU won the previous grant
//   ifu_valid_i : IFU request pending
//   lsu_valid_i : LSU request pending
//   gnt_lsu_o   : 1 selects the LSU, 0 selects the IFU
module biu_rr_arb2 (
    input  logic last_i,
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
    output logic gnt_lsu_o
);
    // Contested: the side that did not win last time gets it.
    // Uncontested (or idle): whoever is valid; defaults to IFU when neither is.
    assign gnt_lsu_o = (ifu_valid_i && lsu_valid_i) ? ~last_i : lsu_valid_i;
endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// sirv_gnrl_dfflr: load-enabled flop with synchronous active-high reset.
//   clk, rst : clock and reset
//   lden_i   : load enable
//   dnxt_i   : next value, captured when lden_i is high
//   qout_o   : registered value (RST_VAL after reset)
module sirv_gnrl_dfflr #(
    parameter int            DW      = 32,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o
);
    logic [DW-1:0] qout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            qout_q <= RST_VAL;
        end else if (lden_i) begin
            qout_q <= dnxt_i;
        end
    end

    assign qout_o = qout_q;
endmodule

// File: rtl/biu_mem_arb.sv
// biu_mem_arb: shares one memory port between the IFU (read-only) and the LSU.
// One transaction is outstanding at a time; the response is returned to the
// owner recorded at grant time, and completed transactions are counted.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : IFU / LSU / memory channels (master modport)
//   ifu_cnt   : completed IFU transactions (wraps)
//   lsu_cnt   : completed LSU transactions (wraps)
//   dbg_state : current FSM state (arb_state_e encoding)
//   dbg_own   : current owner, dbg_last : round-robin pointer
module biu_mem_arb
    import biu_mem_arb_pkg::*;
#(
    parameter int AW = PC_SIZE,
    parameter int DW = XLEN,
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rst,
    biu_mem_arb_if.master   bus,
    output logic [CW-1:0]   ifu_cnt,
    output logic [CW-1:0]   lsu_cnt,
    output logic [1:0]      dbg_state,
    output logic            dbg_own,
    output logic            dbg_last
);
    localparam int SW = DW / 8;

    arb_state_e    state_q, state_d;
    logic [1:0]    state_raw;
    logic          own_q, last_q;
    logic [CW-1:0] ifu_cnt_q, lsu_cnt_q;

    logic          win_lsu;
    logic          sel;
    logic          sel_valid;
    logic          req_active;
    logic          rsp_active;
    logic          req_hs;
    logic          rsp_hs;
    logic [AW-1:0] addr_sel;

    biu_rr_arb2 u_rr (
        .last_i      (last_q),
        .ifu_valid_i (bus.ifu_req_valid),
        .lsu_valid_i (bus.lsu_req_valid),
        .gnt_lsu_o   (win_lsu)
    );

    // In IDLE the fresh round-robin winner is used; once locked (HOLD/RSP)
    // only the recorded owner is seen, so a late rival cannot disturb mem_req_*.
    assign sel        = (state_q == ARB_IDLE) ? win_lsu : own_q;
    assign sel_valid  = sel ? bus.lsu_req_valid : bus.ifu_req_valid;
    assign req_active = !rst && (state_q != ARB_RSP);
    assign rsp_active = !rst && (state_q == ARB_RSP);
    assign addr_sel   = sel ? bus.lsu_req_addr : bus.ifu_req_pc;

    assign bus.mem_req_valid = req_active && sel_valid;
    assign bus.mem_req_addr  = addr_sel;
    assign bus.mem_req_write = sel && bus.lsu_req_write;
    assign bus.mem_req_wdata = sel ? bus.lsu_req_wdata : {DW{1'b0}};
    assign bus.mem_req_wstrb = sel ? bus.lsu_req_wstrb : {SW{1'b0}};

    assign bus.ifu_req_ready = req_active && !sel && bus.ifu_req_valid && bus.mem_req_ready;
    assign bus.lsu_req_ready = req_active &&  sel && bus.lsu_req_valid && bus.mem_req_ready;

    assign req_hs = bus.mem_req_valid && bus.mem_req_ready;

    // Response path: only the owner's channel sees mem_rsp_valid, and only in
    // RSP, so a stale response after reset is neither forwarded nor accepted.
    assign bus.ifu_rsp_valid = rsp_active && (own_q == ARB_OWN_IFU) && bus.mem_rsp_valid;
    assign bus.lsu_rsp_valid = rsp_active && (own_q == ARB_OWN_LSU) && bus.mem_rsp_valid;
    assign bus.mem_rsp_ready = rsp_active && (own_q ? bus.lsu_rsp_ready : bus.ifu_rsp_ready);
    assign bus.ifu_rsp_instr = bus.mem_rsp_rdata;
    assign bus.ifu_rsp_err   = bus.mem_rsp_err;
    assign bus.lsu_rsp_rdata = bus.mem_rsp_rdata;
    assign bus.lsu_rsp_err   = bus.mem_rsp_err;

    assign rsp_hs = bus.mem_rsp_valid && bus.mem_rsp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_hs) begin
                    state_d = ARB_RSP;
                end else if (bus.mem_req_valid) begin
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (req_hs) begin
                    state_d = ARB_RSP;
                end else if (!sel_valid) begin
                    // Owner withdrew before acceptance: drop the grant.
                    state_d = ARB_IDLE;
                end
            end
            ARB_RSP: begin
                if (rsp_hs) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    sirv_gnrl_dfflr #(.DW(2), .RST_VAL(ARB_IDLE)) u_state (
        .clk(clk), .rst(rst), .lden_i(1'b1), .dnxt_i(state_d), .qout_o(state_raw)
    );
    assign state_q = arb_state_e'(state_raw);

    sirv_gnrl_dfflr #(.DW(1), .RST_VAL(ARB_OWN_IFU)) u_own (
        .clk(clk), .rst(rst), .lden_i((state_q == ARB_IDLE) && bus.mem_req_valid),
        .dnxt_i(win_lsu), .qout_o(own_q)
    );

    // Reset to LSU-won so the first contested grant goes to the IFU.
    sirv_gnrl_dfflr #(.DW(1), .RST_VAL(ARB_OWN_LSU)) u_last (
        .clk(clk), .rst(rst), .lden_i(req_hs), .dnxt_i(sel), .qout_o(last_q)
    );

    sirv_gnrl_dfflr #(.DW(CW), .RST_VAL('0)) u_ifu_cnt (
        .clk(clk), .rst(rst), .lden_i(rsp_hs && (own_q == ARB_OWN_IFU)),
        .dnxt_i(ifu_cnt_q + CW'(1)), .qout_o(ifu_cnt_q)
    );

    sirv_gnrl_dfflr #(.DW(CW), .RST_VAL('0)) u_lsu_cnt (
        .clk(clk), .rst(rst), .lden_i(rsp_hs && (own_q == ARB_OWN_LSU)),
        .dnxt_i(lsu_cnt_q + CW'(1)), .qout_o(lsu_cnt_q)
    );

    assign ifu_cnt   = ifu_cnt_q;
    assign lsu_cnt   = lsu_cnt_q;
    assign dbg_state = state_raw;
    assign dbg_own   = own_q;
    assign dbg_last  = last_q;
endmodule

// File: tb/tb_biu_mem_arb.sv
// tb_biu_mem_arb: directed bench for biu_mem_arb. Inputs change 1 ns after
// the rising edge; combinational outputs are checked 1 ns later, and
// registered results are checked after the following edge.
// Counters are built 8 bits wide here so the wrap-around can be reached by
// real transactions.
module tb_biu_mem_arb;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [CW-1:0] ifu_cnt;
    logic [CW-1:0] lsu_cnt;
    logic [1:0]    dbg_state;
    logic          dbg_own;
    logic          dbg_last;

    int checks = 0;
    int errors = 0;

    biu_mem_arb_if #(.AW(32), .DW(32)) bus ();

    biu_mem_arb #(.AW(32), .DW(32), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ifu_cnt   (ifu_cnt),
        .lsu_cnt   (lsu_cnt),
        .dbg_state (dbg_state),
        .dbg_own   (dbg_own),
        .dbg_last  (dbg_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_req_valid = 1'b0;
        bus.ifu_req_pc    = 32'h0;
        bus.ifu_rsp_ready = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_addr  = 32'h0;
        bus.lsu_req_write = 1'b0;
        bus.lsu_req_wdata = 32'h0;
        bus.lsu_req_wstrb = 4'h0;
        bus.lsu_rsp_ready = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        bus.mem_rsp_err   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_mem_req_valid", bus.mem_req_valid, 0);
        chk("rst_ifu_req_ready", bus.ifu_req_ready, 0);
        chk("rst_lsu_req_ready", bus.lsu_req_ready, 0);
        chk("rst_ifu_rsp_valid", bus.ifu_rsp_valid, 0);
        chk("rst_lsu_rsp_valid", bus.lsu_rsp_valid, 0);
        rst = 1'b0;
        settle();
        chk("por_state", dbg_state, 0);
        chk("por_own", dbg_own, 0);
        chk("por_last", dbg_last, 1);
        chk("por_ifu_cnt", ifu_cnt, 0);
        chk("por_lsu_cnt", lsu_cnt, 0);
        chk("por_mem_req_valid", bus.mem_req_valid, 0);

        // Both valid from reset: IFU first, then LSU store.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_2000;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 32'h8000_0100;
        bus.lsu_req_write = 1'b1;
        bus.lsu_req_wdata = 32'hDEAD_BEEF;
        bus.lsu_req_wstrb = 4'hF;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("c1_addr", bus.mem_req_addr, 32'h0000_2000);
        chk("c1_write", bus.mem_req_write, 0);
        chk("c1_wdata", bus.mem_req_wdata, 0);
        chk("c1_wstrb", bus.mem_req_wstrb, 0);
        chk("c1_ifu_ready", bus.ifu_req_ready, 1);
        chk("c1_lsu_ready", bus.lsu_req_ready, 0);
        tick();
        chk("c1_state_rsp", dbg_state, 2);
        chk("c1_last", dbg_last, 0);
        bus.ifu_req_valid = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0000_0013;
        bus.ifu_rsp_ready = 1'b1;
        settle();
        chk("c1_ifu_rsp_valid", bus.ifu_rsp_valid, 1);
        chk("c1_lsu_req_ready_rsp", bus.lsu_req_ready, 0);
        tick();
        chk("c1_ifu_cnt", ifu_cnt, 1);
        chk("c1_state_idle", dbg_state, 0);
        bus.mem_rsp_valid = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_2004;
        settle();
        chk("c2_addr", bus.mem_req_addr, 32'h8000_0100);
        chk("c2_write", bus.mem_req_write, 1);
        chk("c2_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
        chk("c2_wstrb", bus.mem_req_wstrb, 4'hF);
        chk("c2_lsu_ready", bus.lsu_req_ready, 1);
        chk("c2_ifu_ready", bus.ifu_req_ready, 0);
        tick();
        chk("c2_last", dbg_last, 1);
        chk("c2_own", dbg_own, 1);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_write = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0;
        bus.lsu_rsp_ready = 1'b1;
        settle();
        chk("c2_lsu_rsp_valid", bus.lsu_rsp_valid, 1);
        chk("c2_ifu_rsp_valid", bus.ifu_rsp_valid, 0);
        chk("c2_mem_rsp_ready", bus.mem_rsp_ready, 1);
        tick();
        chk("c2_lsu_cnt", lsu_cnt, 1);
        bus.mem_rsp_valid = 1'b0;
        bus.lsu_rsp_ready = 1'b0;

        // IFU only, fetch returns 0x00000413.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_0100;
        settle();
        chk("f_mem_req_valid", bus.mem_req_valid, 1);
        chk("f_addr", bus.mem_req_addr, 32'h0000_0100);
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0000_0413;
        settle();
        chk("f_instr", bus.ifu_rsp_instr, 32'h0000_0413);
        chk("f_ifu_rsp_valid", bus.ifu_rsp_valid, 1);
        chk("f_lsu_rsp_valid", bus.lsu_rsp_valid, 0);
        tick();
        chk("f_ifu_cnt", ifu_cnt, 2);
        bus.mem_rsp_valid = 1'b0;

        // LSU stalled 3 cycles; IFU rises during HOLD and must not steal.
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = 32'h8000_0200;
        bus.mem_req_ready = 1'b0;
        settle();
        chk("h0_addr", bus.mem_req_addr, 32'h8000_0200);
        chk("h0_lsu_ready", bus.lsu_req_ready, 0);
        tick();
        chk("h1_state", dbg_state, 1);
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_3000;
        settle();
        chk("h1_addr", bus.mem_req_addr, 32'h8000_0200);
        chk("h1_ifu_ready", bus.ifu_req_ready, 0);
        tick();
        chk("h2_addr", bus.mem_req_addr, 32'h8000_0200);
        chk("h2_ifu_ready", bus.ifu_req_ready, 0);
        tick();
        bus.mem_req_ready = 1'b1;
        settle();
        chk("h3_addr", bus.mem_req_addr, 32'h8000_0200);
        chk("h3_lsu_ready", bus.lsu_req_ready, 1);
        chk("h3_ifu_ready", bus.ifu_req_ready, 0);
        tick();
        chk("h3_state_rsp", dbg_state, 2);

        // LSU response back-pressure, error passes through.
        bus.lsu_req_valid = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'hCAFE_F00D;
        bus.mem_rsp_err   = 1'b1;
        bus.lsu_rsp_ready = 1'b0;
        settle();
        chk("bp1_lsu_rsp_valid", bus.lsu_rsp_valid, 1);
        chk("bp1_mem_rsp_ready", bus.mem_rsp_ready, 0);
        chk("bp1_ifu_rsp_valid", bus.ifu_rsp_valid, 0);
        chk("bp1_ifu_req_ready", bus.ifu_req_ready, 0);
        tick();
        chk("bp2_state", dbg_state, 2);
        chk("bp2_mem_rsp_ready", bus.mem_rsp_ready, 0);
        tick();
        bus.lsu_rsp_ready = 1'b1;
        settle();
        chk("bp3_mem_rsp_ready", bus.mem_rsp_ready, 1);
        chk("bp3_err", bus.lsu_rsp_err, 1);
        chk("bp3_rdata", bus.lsu_rsp_rdata, 32'hCAFE_F00D);
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_err   = 1'b0;
        bus.lsu_rsp_ready = 1'b0;
        settle();
        chk("bp_lsu_cnt", lsu_cnt, 2);
        chk("bp_ifu_cnt", ifu_cnt, 2);
        chk("bp_state", dbg_state, 0);

        // Owner withdraws during HOLD: back to IDLE, no count.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_req_pc    = 32'h0000_4000;
        bus.mem_req_ready = 1'b0;
        tick();
        chk("wd_state_hold", dbg_state, 1);
        bus.ifu_req_valid = 1'b0;
        settle();
        chk("wd_mem_req_valid", bus.mem_req_valid, 0);
        tick();
        chk("wd_state_idle", dbg_state, 0);
        chk("wd_ifu_cnt", ifu_cnt, 2);

        // Reset while a response is outstanding; late response is dropped.
        bus.ifu_req_valid = 1'b1;
        bus.mem_req_ready = 1'b1;
        tick();
        chk("rr_state_rsp", dbg_state, 2);
        bus.ifu_req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.ifu_rsp_ready = 1'b1;
        bus.lsu_rsp_ready = 1'b1;
        settle();
        chk("rr_ifu_rsp_valid", bus.ifu_rsp_valid, 0);
        chk("rr_lsu_rsp_valid", bus.lsu_rsp_valid, 0);
        chk("rr_mem_rsp_ready", bus.mem_rsp_ready, 0);
        chk("rr_state", dbg_state, 0);
        chk("rr_last", dbg_last, 1);
        tick();
        chk("rr_state2", dbg_state, 0);
        chk("rr_ifu_cnt", ifu_cnt, 0);
        chk("rr_lsu_cnt", lsu_cnt, 0);
        bus.mem_rsp_valid = 1'b0;
        bus.lsu_rsp_ready = 1'b0;

        // Back-to-back IFU fetches up to and across the counter wrap.
        bus.ifu_req_pc = 32'h0000_5000;
        for (int i = 0; i < 256; i++) begin
            bus.ifu_req_valid = 1'b1;
            bus.mem_rsp_valid = 1'b0;
            tick();
            bus.mem_rsp_valid = 1'b1;
            settle();
            chk("bb_rsp_cycle_req_ready", bus.ifu_req_ready, 0);
            chk("bb_ifu_rsp_valid", bus.ifu_rsp_valid, 1);
            tick();
            if (i == 254) chk("wrap_pre", ifu_cnt, 8'hFF);
        end
        bus.ifu_req_valid = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("wrap_zero", ifu_cnt, 0);
        chk("wrap_lsu_cnt", lsu_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
